// File: rtl/ice_event_arbiter.sv
// ice_event_arbiter: latches masked event strobes and serves the highest-priority one over REQ/ACK with timeout
module ice_event_arbiter #(
  parameter int TO_W   = 8,
  parameter int TO_MAX = 200
) (
  input  logic       CLK,
  input  logic       SYSRS,
  input  logic [9:0] EVREQ,
  input  logic [9:0] EVMASK,
  input  logic       ICEEVACK,
  input  logic       ICEEVTOCLR,
  output logic       ICEEVREQ,
  output logic [3:0] ICEEVCODE,
  output logic [9:0] ICEEVPEND,
  output logic       ICEEVTO
);
  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
  state_t          state_q;
  logic [9:0]      pend_q, elig, clr;
  logic [3:0]      sel, code_q;
  logic [TO_W-1:0] cnt_q;
  logic            req_q, to_q, ack_hit, to_hit;
  assign elig    = pend_q & ~EVMASK;
  assign ack_hit = (state_q == REQ) && ICEEVACK;
  assign to_hit  = (state_q == REQ) && !ICEEVACK && (cnt_q == TO_W'(TO_MAX - 1));
  assign clr     = ack_hit ? (10'd1 << (code_q - 4'd1)) : 10'd0;
  // highest set eligible bit wins; ascending scan lets later (higher) bits overwrite
  always_comb begin
    sel = 4'd0;
    for (int i = 0; i < 10; i++) sel = elig[i] ? 4'(i) : sel;
  end
  // pending flags, sticky timeout and the IDLE/REQ/GAP handshake sequencer
  always_ff @(posedge CLK) begin
    if (SYSRS) begin
      state_q <= IDLE;
      pend_q  <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      pend_q <= (pend_q & ~clr) | (EVREQ & ~EVMASK);
      to_q   <= to_hit | (to_q & ~ICEEVTOCLR);
      case (state_q)
        IDLE: if (|elig) begin
          code_q  <= sel + 4'd1;
          cnt_q   <= '0;
          req_q   <= 1'b1;
          state_q <= REQ;
        end
        REQ: if (ack_hit || to_hit) begin
          code_q  <= '0;
          req_q   <= 1'b0;
          state_q <= GAP;
        end else cnt_q <= cnt_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ICEEVREQ  = req_q;
  assign ICEEVCODE = code_q;
  assign ICEEVPEND = pend_q;
  assign ICEEVTO   = to_q;
endmodule

// File: tb/tb_ice_event_arbiter.sv
// tb_ice_event_arbiter: directed scoreboard bench for the ICE event arbiter
module tb_ice_event_arbiter;
  localparam int TO_MAX = 200;
  logic       clk = 1'b0, rst = 1'b1;
  logic [9:0] evreq = '0, evmask = '0;
  logic       ack = 1'b0, toclr = 1'b0;
  logic       req, to;
  logic [3:0] code;
  logic [9:0] pend;
  int         n_chk = 0, n_fail = 0;
  logic [3:0] exp_q[$];
  logic       req_prev = 1'b0;
  ice_event_arbiter #(.TO_W(8), .TO_MAX(TO_MAX)) dut (
    .CLK(clk), .SYSRS(rst), .EVREQ(evreq), .EVMASK(evmask), .ICEEVACK(ack),
    .ICEEVTOCLR(toclr), .ICEEVREQ(req), .ICEEVCODE(code), .ICEEVPEND(pend), .ICEEVTO(to)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_zero(input string tag);
    chk({tag, "_req"}, 32'(req), 0);
    chk({tag, "_code"}, 32'(code), 0);
    chk({tag, "_pend"}, 32'(pend), 0);
    chk({tag, "_to"}, 32'(to), 0);
  endtask
  // scoreboard: every new request must match the oldest expected code
  always @(negedge clk) begin
    if (req && !req_prev) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL sb_unexpected observed=%0h expected=none", code);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        assert (code === e) else begin
          n_fail++;
          $error("FAIL sb_code observed=%0h expected=%0h", code, e);
        end
      end
    end
    req_prev = req;
  end
  initial begin
    tick(); tick();
    // 1: reset dominates strobes
    evreq = 10'h3FF;
    tick();
    idle_zero("rst");
    evreq = '0; rst = 1'b0;
    repeat (5) tick();
    idle_zero("idle5");
    // 2: single event latency and ack
    evreq = 10'h008; exp_q.push_back(4'd4);
    tick(); evreq = '0;
    chk("t2_pend_n1", 32'(pend), 32'h008);
    chk("t2_req_n1", 32'(req), 0);
    tick();
    chk("t2_req_n2", 32'(req), 1);
    chk("t2_code_n2", 32'(code), 4);
    tick(); tick();
    ack = 1'b1;
    tick(); ack = 1'b0;
    chk("t2_pend_n5", 32'(pend), 0);
    chk("t2_req_n5", 32'(req), 0);
    tick();
    // 3: priority, gap then next event
    evreq = 10'h201; exp_q.push_back(4'd10); exp_q.push_back(4'd1);
    tick(); evreq = '0;
    tick();
    chk("t3_code_hi", 32'(code), 10);
    ack = 1'b1;
    tick(); ack = 1'b0;
    chk("t3_pend_gap", 32'(pend), 32'h001);
    chk("t3_req_gap", 32'(req), 0);
    chk("t3_code_gap", 32'(code), 0);
    tick();
    chk("t3_req_idle", 32'(req), 0);
    tick();
    chk("t3_code_lo", 32'(code), 1);
    ack = 1'b1;
    tick(); ack = 1'b0;
    chk("t3_pend_done", 32'(pend), 0);
    tick(); tick();
    // ack outside REQ is ignored
    ack = 1'b1; tick(); ack = 1'b0;
    idle_zero("t3_stray_ack");
    // 4: masked strobe dropped; masked pending bit ineligible
    evmask = 10'h010; evreq = 10'h010;
    tick(); evreq = '0;
    chk("t4_masked_pend", 32'(pend), 0);
    tick(); tick();
    chk("t4_masked_req", 32'(req), 0);
    evmask = '0; evreq = 10'h004;
    tick(); evreq = '0; evmask = 10'h004;
    chk("t4_pend2", 32'(pend), 32'h004);
    repeat (3) tick();
    chk("t4_noreq", 32'(req), 0);
    chk("t4_pend_kept", 32'(pend), 32'h004);
    evmask = '0; exp_q.push_back(4'd3);
    tick();
    chk("t4_req_unmask", 32'(req), 1);
    chk("t4_code_unmask", 32'(code), 3);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t4_pend_done", 32'(pend), 0);
    tick(); tick();
    // 5: ack timeout, reissue, sticky flag clear and set-wins
    evreq = 10'h020; exp_q.push_back(4'd6);
    tick(); evreq = '0;
    tick();
    chk("t5_req_first", 32'(req), 1);
    repeat (TO_MAX - 1) tick();
    chk("t5_req_last", 32'(req), 1);
    chk("t5_to_before", 32'(to), 0);
    exp_q.push_back(4'd6);
    tick();
    chk("t5_to_set", 32'(to), 1);
    chk("t5_req_gap", 32'(req), 0);
    chk("t5_pend_kept", 32'(pend), 32'h020);
    tick();
    chk("t5_req_idle", 32'(req), 0);
    tick();
    chk("t5_reissue", 32'(req), 1);
    toclr = 1'b1; tick(); toclr = 1'b0;
    chk("t5_toclr", 32'(to), 0);
    repeat (TO_MAX - 2) tick();
    chk("t5_req_last2", 32'(req), 1);
    chk("t5_to_before2", 32'(to), 0);
    toclr = 1'b1; exp_q.push_back(4'd6);
    tick(); toclr = 1'b0;
    chk("t5_set_wins", 32'(to), 1);
    chk("t5_req_gap2", 32'(req), 0);
    tick(); tick();
    chk("t5_reissue2", 32'(req), 1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t5_pend_done", 32'(pend), 0);
    toclr = 1'b1; tick(); toclr = 1'b0;
    chk("t5_to_clr2", 32'(to), 0);
    tick();
    // 6: set wins over ack clear, then reset mid-REQ
    evreq = 10'h010; exp_q.push_back(4'd5);
    tick(); evreq = '0;
    tick();
    chk("t6_code", 32'(code), 5);
    ack = 1'b1; evreq = 10'h010; exp_q.push_back(4'd5);
    tick(); ack = 1'b0; evreq = '0;
    chk("t6_pend_kept", 32'(pend), 32'h010);
    tick(); tick();
    chk("t6_reserved", 32'(req), 1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    idle_zero("t6_rst");
    tick(); tick();
    idle_zero("t6_after");
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
